// File: rtl/cache_pkg.sv
// cache_pkg: shared state enum, byte-lane type and address-field widths for the write-back data cache.
package cache_pkg;
   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
   typedef logic [7:0] byte_t;
   function automatic int off_w(input int words);
      return $clog2(words);
   endfunction
   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction
   localparam int OFF_W = off_w(4);
   localparam int IDX_W = idx_w(16);
   localparam int TAG_W = 30 - OFF_W - IDX_W;
endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: valid/dirty/tag/data arrays with byte-lane synchronous write and combinational read.
module cache_line_store
   import cache_pkg::*;
#(
   parameter int LINES = 16,
   parameter int WORDS = 4,
   parameter int IW = IDX_W,
   parameter int TW = TAG_W,
   parameter int CW = OFF_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [IW-1:0] idx_i,
   input  logic [CW-1:0] woff_i,
   output logic          valid_o,
   output logic          dirty_o,
   output logic [TW-1:0] tag_o,
   output logic [31:0]   word_o,
   input  logic          wr_en_i,
   input  logic [3:0]    wr_be_i,
   input  logic [31:0]   wr_data_i,
   input  logic          meta_we_i,
   input  logic          meta_valid_i,
   input  logic          meta_dirty_i,
   input  logic [TW-1:0] meta_tag_i
);
   localparam int AW = IW + $clog2(WORDS);
   logic [LINES-1:0] valid_q, dirty_q;
   logic [TW-1:0] tag_q [LINES];
   logic [31:0] data_q [LINES*WORDS];
   logic [AW-1:0] a;
   assign a = AW'(int'(idx_i) * WORDS + int'(woff_i));
   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];
   assign tag_o = tag_q[idx_i];
   assign word_o = data_q[a];
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (meta_we_i) begin
         valid_q[idx_i] <= meta_valid_i;
         dirty_q[idx_i] <= meta_dirty_i;
      end
   end
   // Payload arrays are deliberately left unreset; valid gates their use.
   always_ff @(posedge clk) begin
      if (meta_we_i)
         tag_q[idx_i] <= meta_tag_i;
      if (wr_en_i)
         for (int b = 0; b < 4; b++)
            if (wr_be_i[b])
               data_q[a][8*b +: 8] <= wr_data_i[8*b +: 8];
   end
endmodule

// File: rtl/cache_wb_dm.sv
// cache_wb_dm: direct-mapped write-back data cache; hits answer in the request cycle,
// misses stall through ready while the block is written back and/or refilled word by word.
module cache_wb_dm
   import cache_pkg::*;
#(
   parameter int LINES = 16,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   input  logic [31:0] data_in,
   input  logic [31:0] mem_data_out,
   input  logic        byte_mode,
   input  logic        write_enable,
   input  logic        enable,
   output logic [31:0] data_out,
   output logic [31:0] output_mem_addr,
   output logic [31:0] mem_data_in,
   output logic        mem_write_en,
   output logic        ready
);
   localparam int OW = off_w(WORDS_PER_BLOCK);
   localparam int IW = idx_w(LINES);
   localparam int TW = 30 - OW - IW;
   localparam int CW = (OW > 0) ? OW : 1;
   localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int IDX_SH = OW + 2;
   localparam int TAG_SH = IW + OW + 2;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [TW-1:0] vtag_q, vtag_d, rtag_q, rtag_d, req_tag, rd_tag, meta_tag;
   logic [IW-1:0] idx_q, idx_d, req_idx, st_idx;
   logic [CW-1:0] req_woff, st_woff;
   logic rd_valid, rd_dirty, hit, last_lat, last_word;
   logic wr_en, meta_we, meta_dirty;
   logic [3:0] wr_be;
   logic [31:0] rd_word, wr_data, blk;
   byte_t rd_byte;
   assign req_tag = TW'(mem_addr >> TAG_SH);
   assign req_idx = IW'(mem_addr >> IDX_SH);
   assign req_woff = CW'((mem_addr >> 2) & 32'(WORDS_PER_BLOCK - 1));
   // The store is addressed by the live request in IDLE and by the latched miss otherwise.
   assign st_idx = (state_q == IDLE) ? req_idx : idx_q;
   assign st_woff = (state_q == IDLE) ? req_woff : cnt_q;
   assign hit = enable && rd_valid && (rd_tag == req_tag);
   assign last_lat = lat_q == LW'(MEM_LATENCY - 1);
   assign last_word = cnt_q == CW'(WORDS_PER_BLOCK - 1);
   assign rd_byte = byte_t'(rd_word >> {mem_addr[1:0], 3'b000});
   assign blk = (32'(idx_q) << IDX_SH) | (32'(cnt_q) << 2);
   cache_line_store #(
      .LINES(LINES),
      .WORDS(WORDS_PER_BLOCK),
      .IW(IW),
      .TW(TW),
      .CW(CW)
   ) u_store (
      .clk(clk),
      .reset(reset),
      .idx_i(st_idx),
      .woff_i(st_woff),
      .valid_o(rd_valid),
      .dirty_o(rd_dirty),
      .tag_o(rd_tag),
      .word_o(rd_word),
      .wr_en_i(wr_en),
      .wr_be_i(wr_be),
      .wr_data_i(wr_data),
      .meta_we_i(meta_we),
      .meta_valid_i(1'b1),
      .meta_dirty_i(meta_dirty),
      .meta_tag_i(meta_tag)
   );
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      lat_d = lat_q;
      vtag_d = vtag_q;
      rtag_d = rtag_q;
      idx_d = idx_q;
      ready = 1'b0;
      data_out = '0;
      output_mem_addr = {mem_addr[31:2], 2'b00};
      mem_data_in = '0;
      mem_write_en = 1'b0;
      wr_en = 1'b0;
      wr_be = 4'hF;
      wr_data = mem_data_out;
      meta_we = 1'b0;
      meta_dirty = 1'b0;
      meta_tag = rtag_q;
      case (state_q)
         IDLE: begin
            ready = hit;
            data_out = !hit ? '0 : byte_mode ? {24'h0, rd_byte} : rd_word;
            if (hit && write_enable) begin
               wr_en = 1'b1;
               wr_be = byte_mode ? 4'b0001 << mem_addr[1:0] : 4'hF;
               wr_data = byte_mode ? {4{data_in[7:0]}} : data_in;
               meta_we = 1'b1;
               meta_dirty = 1'b1;
               meta_tag = req_tag;
            end else if (enable && !hit) begin
               idx_d = req_idx;
               rtag_d = req_tag;
               vtag_d = rd_tag;
               cnt_d = '0;
               lat_d = '0;
               state_d = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
            end
         end
         WRITEBACK: begin
            output_mem_addr = (32'(vtag_q) << TAG_SH) | blk;
            mem_data_in = rd_word;
            mem_write_en = 1'b1;
            lat_d = last_lat ? '0 : lat_q + 1'b1;
            if (last_lat) begin
               cnt_d = last_word ? '0 : cnt_q + 1'b1;
               if (last_word) begin
                  meta_we = 1'b1;
                  meta_tag = vtag_q;
                  state_d = REFILL;
               end
            end
         end
         REFILL: begin
            output_mem_addr = (32'(rtag_q) << TAG_SH) | blk;
            lat_d = last_lat ? '0 : lat_q + 1'b1;
            if (last_lat) begin
               wr_en = 1'b1;
               cnt_d = last_word ? '0 : cnt_q + 1'b1;
               if (last_word) begin
                  meta_we = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (reset) begin
         ready = 1'b0;
         data_out = '0;
         mem_write_en = 1'b0;
         wr_en = 1'b0;
         meta_we = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         lat_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         lat_q <= lat_d;
      end
   end
   always_ff @(posedge clk) begin
      vtag_q <= vtag_d;
      rtag_q <= rtag_d;
      idx_q <= idx_d;
   end
endmodule

// File: tb/tb_cache_wb_dm.sv
// tb_cache_wb_dm: directed checks of the write-back cache in the default and a long-latency configuration.
module tb_cache_wb_dm;
   logic clk = 1'b0;
   logic reset;
   logic [31:0] mem_addr, data_in, mem_data_out, data_out, output_mem_addr, mem_data_in;
   logic byte_mode, write_enable, enable, mem_write_en, ready;
   logic [31:0] l_addr, l_mdo, l_dout, l_oaddr, l_mdi;
   logic l_en, l_mwe, l_ready;
   logic [31:0] wb3 [4];
   logic [31:0] wb4 [4];
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Main memory model: word k of a block reads as {addr[15:0], 8'h00, 8'h11*(k+1)}.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      logic [7:0] k;
      k = 8'(a[3:2]) + 8'd1;
      return {a[15:0], 8'h00, 8'h11 * k};
   endfunction

   assign mem_data_out = mem_val(output_mem_addr);
   assign l_mdo = mem_val(l_oaddr);

   cache_wb_dm u_dut (
      .clk(clk),
      .reset(reset),
      .mem_addr(mem_addr),
      .data_in(data_in),
      .mem_data_out(mem_data_out),
      .byte_mode(byte_mode),
      .write_enable(write_enable),
      .enable(enable),
      .data_out(data_out),
      .output_mem_addr(output_mem_addr),
      .mem_data_in(mem_data_in),
      .mem_write_en(mem_write_en),
      .ready(ready)
   );

   cache_wb_dm #(.LINES(16), .WORDS_PER_BLOCK(2), .MEM_LATENCY(3)) u_lat (
      .clk(clk),
      .reset(reset),
      .mem_addr(l_addr),
      .data_in(32'h0),
      .mem_data_out(l_mdo),
      .byte_mode(1'b0),
      .write_enable(1'b0),
      .enable(l_en),
      .data_out(l_dout),
      .output_mem_addr(l_oaddr),
      .mem_data_in(l_mdi),
      .mem_write_en(l_mwe),
      .ready(l_ready)
   );

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input logic [31:0] a, input logic we, input logic bm, input logic [31:0] d);
      mem_addr = a;
      write_enable = we;
      byte_mode = bm;
      data_in = d;
      enable = 1'b1;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      wb3 = '{32'h00400011, 32'hDEADBEEF, 32'h00480033, 32'h004C0044};
      wb4 = '{32'h0280AA11, 32'h02840022, 32'h02880033, 32'h028C0044};
      reset = 1'b1;
      enable = 1'b0;
      write_enable = 1'b0;
      byte_mode = 1'b0;
      mem_addr = '0;
      data_in = '0;
      l_en = 1'b0;
      l_addr = '0;
      tick;
      set_req(32'h40, 1'b0, 1'b0, 32'h0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_mwe", 32'(mem_write_en), 32'd0);
      chk("rst_dout", data_out, 32'h0);
      tick;
      reset = 1'b0;
      #1;
      chk("cold_req_ready", 32'(ready), 32'd0);
      chk("cold_req_addr", output_mem_addr, 32'h40);
      for (int k = 0; k < 4; k++) begin
         tick;
         chk("cold_addr", output_mem_addr, 32'h40 + 32'(4 * k));
         chk("cold_busy", 32'(ready), 32'd0);
         chk("cold_mwe", 32'(mem_write_en), 32'd0);
      end
      tick;
      chk("cold_ready", 32'(ready), 32'd1);
      chk("cold_data", data_out, 32'h00400011);
      tick;
      set_req(32'h44, 1'b1, 1'b0, 32'hDEADBEEF);
      chk("wr_hit_ready", 32'(ready), 32'd1);
      tick;
      set_req(32'h46, 1'b0, 1'b1, 32'h0);
      chk("byte_rd_ready", 32'(ready), 32'd1);
      chk("byte_rd_data", data_out, 32'h000000AD);
      tick;
      set_req(32'h44, 1'b0, 1'b0, 32'h0);
      chk("word_rd_data", data_out, 32'hDEADBEEF);
      enable = 1'b0;
      #1;
      chk("idle_no_ready", 32'(ready), 32'd0);
      tick;
      set_req(32'h140, 1'b0, 1'b0, 32'h0);
      chk("evict_req_ready", 32'(ready), 32'd0);
      chk("evict_req_mwe", 32'(mem_write_en), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick;
         chk("wb_mwe", 32'(mem_write_en), 32'd1);
         chk("wb_addr", output_mem_addr, 32'h40 + 32'(4 * k));
         chk("wb_data", mem_data_in, wb3[k]);
      end
      for (int k = 0; k < 4; k++) begin
         tick;
         chk("evict_rf_mwe", 32'(mem_write_en), 32'd0);
         chk("evict_rf_addr", output_mem_addr, 32'h140 + 32'(4 * k));
         chk("evict_rf_busy", 32'(ready), 32'd0);
      end
      tick;
      chk("evict_ready", 32'(ready), 32'd1);
      chk("evict_data", data_out, 32'h01400011);
      tick;
      set_req(32'h281, 1'b1, 1'b1, 32'h000000AA);
      chk("bw_req_ready", 32'(ready), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick;
         chk("bw_rf_addr", output_mem_addr, 32'h280 + 32'(4 * k));
         chk("bw_rf_mwe", 32'(mem_write_en), 32'd0);
      end
      tick;
      chk("bw_hit_ready", 32'(ready), 32'd1);
      tick;
      set_req(32'h280, 1'b0, 1'b0, 32'h0);
      chk("bw_merged", data_out, 32'h0280AA11);
      tick;
      set_req(32'h80, 1'b0, 1'b0, 32'h0);
      chk("bw_evict_req", 32'(ready), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick;
         chk("bw_wb_mwe", 32'(mem_write_en), 32'd1);
         chk("bw_wb_addr", output_mem_addr, 32'h280 + 32'(4 * k));
         chk("bw_wb_data", mem_data_in, wb4[k]);
      end
      for (int k = 0; k < 4; k++) begin
         tick;
         chk("bw_rf2_addr", output_mem_addr, 32'h80 + 32'(4 * k));
      end
      tick;
      chk("bw_evict_ready", 32'(ready), 32'd1);
      chk("bw_evict_data", data_out, 32'h00800011);
      tick;
      set_req(32'h300, 1'b0, 1'b0, 32'h0);
      chk("rr_req_ready", 32'(ready), 32'd0);
      tick;
      tick;
      tick;
      chk("rr_word2_addr", output_mem_addr, 32'h308);
      reset = 1'b1;
      #1;
      chk("rr_rst_ready", 32'(ready), 32'd0);
      chk("rr_rst_mwe", 32'(mem_write_en), 32'd0);
      chk("rr_rst_dout", data_out, 32'h0);
      tick;
      reset = 1'b0;
      #1;
      chk("rr_idle_ready", 32'(ready), 32'd0);
      chk("rr_idle_addr", output_mem_addr, 32'h300);
      for (int k = 0; k < 4; k++) begin
         tick;
         chk("rr_rf_addr", output_mem_addr, 32'h300 + 32'(4 * k));
         chk("rr_rf_busy", 32'(ready), 32'd0);
      end
      tick;
      chk("rr_ready", 32'(ready), 32'd1);
      chk("rr_data", data_out, 32'h03000011);
      tick;
      set_req(32'h140, 1'b0, 1'b0, 32'h0);
      chk("rr_inval_ready", 32'(ready), 32'd0);
      enable = 1'b0;
      l_addr = 32'h40;
      l_en = 1'b1;
      #1;
      chk("lat_req_ready", 32'(l_ready), 32'd0);
      for (int c = 1; c <= 6; c++) begin
         tick;
         chk("lat_addr", l_oaddr, (c <= 3) ? 32'h40 : 32'h44);
         chk("lat_busy", 32'(l_ready), 32'd0);
         chk("lat_mwe", 32'(l_mwe), 32'd0);
      end
      tick;
      chk("lat_ready", 32'(l_ready), 32'd1);
      chk("lat_data", l_dout, 32'h00400011);
      l_en = 1'b0;
      tick;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cache_wb_dm.md
Name: cache_wb_dm

Overview:
- Parametrised direct-mapped write-back data cache between the MIPS memory stage and word-wide main memory.
- Replaces the pass-through cache. Keeps the same requester-side interface, adding a multi-word block refill/write-back engine with a ready handshake.
- Supports word and byte reads and writes. Hits complete in the request cycle; misses stall the pipeline through ready.

Parameters:
- LINES, 16: number of cache lines. Power of two, ≥2.
- WORDS_PER_BLOCK, 4: 32-bit words per line. Power of two, ≥1.
- MEM_LATENCY, 1: cycles main memory needs per word access. ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mem_addr  in  32  byte address of the request.
- data_in  in  4x8  write data; byte lane [0] is used in byte mode.
- mem_data_out  in  4x8  read data from main memory.
- byte_mode  in  1  1 = byte access, 0 = word access.
- write_enable  in  1  1 = write, 0 = read.
- enable  in  1  request valid.
- data_out  out  4x8  read data to requester.
- output_mem_addr  out  32  word-aligned address to main memory.
- mem_data_in  out  4x8  write-back data to main memory.
- mem_write_en  out  1  main-memory write strobe.
- ready  out  1  request completes this cycle.

Behaviour:
- Address split:
  - byte offset = [1:0]
  - word offset = next log2(WORDS_PER_BLOCK) bits
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Word mode ignores addr[1:0].
- Each line holds valid, dirty, tag and WORDS_PER_BLOCK words.
- FSM states: IDLE, WRITEBACK, REFILL. Counters: word_cnt (0..WORDS_PER_BLOCK-1) and lat_cnt (0..MEM_LATENCY-1). Victim tag and index are latched on miss entry.
- IDLE:
  - hit = enable & valid[idx] & (tag[idx]==req_tag).
  - ready = hit, combinational, zero-latency.
  - Read hit:
    - Word mode: data_out = the stored word.
    - Byte mode: data_out[0] = the selected byte, lanes 1-3 = 0.
  - Write hit: at the clock edge, update the word (or only the selected byte) and set dirty.
  - Miss with dirty victim: go to WRITEBACK. Miss with clean or invalid victim: go to REFILL.
  - enable=0: ready=0, no state change.
- WRITEBACK:
  - output_mem_addr = {victim_tag, idx, word_cnt, 2'b00}.
  - mem_data_in = the stored word; mem_write_en = 1.
  - Each word is held MEM_LATENCY cycles.
  - After the last word, clear dirty and go to REFILL.
- REFILL:
  - output_mem_addr = {req_tag, idx, word_cnt, 2'b00}.
  - mem_data_out is captured into the line when lat_cnt == MEM_LATENCY-1.
  - After the last word, set valid=1, tag=req_tag, dirty=0, and go to IDLE. The request then hits in the following cycle.
- Miss latency, request cycle to ready cycle:
  - Clean miss: 1 + W*L.
  - Dirty miss: 1 + 2*W*L.
  - W = WORDS_PER_BLOCK, L = MEM_LATENCY.
- ready=0 in WRITEBACK and REFILL. mem_write_en=0 outside WRITEBACK.
- In IDLE, output_mem_addr = {mem_addr[31:2], 2'b00} and mem_data_in = 0.
- Requester holds all request inputs stable until ready. Changing them mid-miss is illegal; the FSM completes the latched miss regardless.
- A write miss refills first, then writes as a hit. There is no write-allocate bypass.
- Reset:
  - Clears all valid and dirty bits and both counters; FSM returns to IDLE.
  - Reset during WRITEBACK or REFILL aborts the transfer. Dirty data is discarded and no further memory writes occur.
  - During the reset cycle: ready=0, mem_write_en=0, data_out=0.
- Data and tag arrays are not reset.

Decomposition:
- Package cache_pkg holds:
  - the state enum (IDLE, WRITEBACK, REFILL)
  - localparam widths OFF_W, IDX_W, TAG_W, derived via $clog2
  - the byte-lane type (logic [7:0])
- One sub-module, cache_line_store, holds the valid, dirty, tag and data arrays. It has synchronous write (word or byte-lane enable) and combinational read.
- FSM and address muxing stay in cache_wb_dm.

Test Plan:
All scenarios use the default parameters (LINES=16, W=4, L=1). Addresses 0x40 and 0x140 map to index 4, with tags 0 and 1.

- Cold read:
  - Stimulus: after reset, read word 0x40; memory returns 0x11,0x22,0x33,0x44 for word k=0..3.
  - Required: output_mem_addr steps 0x40,0x44,0x48,0x4C over 4 cycles; ready in cycle 5; data_out = word 0; mem_write_en never 1.
- Write hit, then byte read:
  - Stimulus: word write 0xDEADBEEF to 0x44 (ready same cycle), then byte read 0x46.
  - Required: data_out[0] = byte lane 2 of the written word (0xAD); lanes 1-3 = 0.
- Dirty eviction:
  - Stimulus: after scenario 2, read 0x140.
  - Required: 4 WRITEBACK cycles with mem_write_en=1 and addresses 0x40..0x4C, with the updated 0x44 word on mem_data_in; then 4 REFILL cycles at 0x140..0x14C; ready in cycle 9.
- Byte write miss:
  - Stimulus: byte write 0xAA to 0x281 with line 8 clean.
  - Required: refill 0x280..0x28C; in the next cycle only byte lane 1 is updated and dirty=1. A subsequent conflicting read writes back the merged word.
- Reset mid-refill:
  - Stimulus: assert reset in REFILL word 2.
  - Required: FSM in IDLE next cycle; ready=0 and mem_write_en=0 during reset; the same read re-misses and performs a full 4-word refill.
- Latency sweep:
  - Stimulus: MEM_LATENCY=3, WORDS_PER_BLOCK=2; clean miss.
  - Required: each address held 3 cycles; ready in cycle 7.
